// File: rtl/dmc_pkg.sv
// Shared types and constants for the dual-mode count scheduler.
// Imported by the interface, the arbiter and the scheduler top.
package dmc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_FREE = 1'b0;
   localparam logic MODE_TICK = 1'b1;
   localparam int   NREQ      = 2;

   function automatic logic [NREQ-1:0] onehot(input logic idx);
      return idx ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/dmc_sched_if.sv
// Client-facing bundle of the scheduler: requests, targets and modes in,
// grant/done/count status out. err exists only with DMC_SCHED_TIMEOUT_EN.
interface dmc_sched_if #(
   parameter int WIDTH = 4
);
   import dmc_pkg::*;

   logic [NREQ-1:0]  req;
   logic             mode0;
   logic             mode1;
   logic [WIDTH-1:0] tgt0;
   logic [WIDTH-1:0] tgt1;
   logic             tick;
   logic [NREQ-1:0]  gnt;
   logic             busy;
   logic [NREQ-1:0]  done;
   logic [WIDTH-1:0] count;
   logic             act_mode;
`ifdef DMC_SCHED_TIMEOUT_EN
   logic             err;

   modport master (
      output req, mode0, mode1, tgt0, tgt1, tick,
      input  gnt, busy, done, count, act_mode, err
   );

   modport slave (
      input  req, mode0, mode1, tgt0, tgt1, tick,
      output gnt, busy, done, count, act_mode, err
   );
`else
   modport master (
      output req, mode0, mode1, tgt0, tgt1, tick,
      input  gnt, busy, done, count, act_mode
   );

   modport slave (
      input  req, mode0, mode1, tgt0, tgt1, tick,
      output gnt, busy, done, count, act_mode
   );
`endif

endinterface

// File: rtl/dmc_rr_arb.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to
// the client named by the priority pointer. Purely combinational.
module dmc_rr_arb
   import dmc_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic            ptr,
   output logic [NREQ-1:0] gnt,
   output logic            win
);

   always_comb begin
      gnt = '0;
      win = ptr;
      case (req)
         2'b01: begin
            win = 1'b0;
            gnt = onehot(1'b0);
         end
         2'b10: begin
            win = 1'b1;
            gnt = onehot(1'b1);
         end
         2'b11: begin
            win = ptr;
            gnt = onehot(ptr);
         end
         default: begin
            win = ptr;
            gnt = '0;
         end
      endcase
   end

endmodule

// File: rtl/dmc_sched.sv
// Scheduler for the shared count resource: grants one of two clients, counts
// 0..target in free-run or tick-gated mode, then pulses done to the owner.
// Optional watchdog on tick-gated runs enabled by DMC_SCHED_TIMEOUT_EN.
module dmc_sched
   import dmc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input logic        clk,
   input logic        rst,
   dmc_sched_if.slave bus
);

   state_t           state_q;
   state_t           state_d;
   logic             owner_q;
   logic             ptr_q;
   logic             mode_q;
   logic [WIDTH-1:0] tgt_q;
   logic [WIDTH-1:0] count_q;
   logic [NREQ-1:0]  gnt_q;
   logic [NREQ-1:0]  arb_gnt;
   logic             arb_win;
   logic             do_grant;
   logic             do_inc;
   logic             do_release;
   logic             owner_req;
   logic             step;
   logic             at_tgt;

   dmc_rr_arb u_arb (
      .req (bus.req),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .win (arb_win)
   );

   assign owner_req = bus.req[owner_q];
   assign step      = (mode_q == MODE_FREE) || bus.tick;
   assign at_tgt    = (count_q == tgt_q);

`ifdef DMC_SCHED_TIMEOUT_EN
   localparam logic [WIDTH:0] WD_LAST = {1'b0, {WIDTH{1'b1}}};

   logic [WIDTH:0] idle_q;
   logic           wd_expire;
   logic           do_err;
   logic           err_q;

   // Expires on the tick-less cycle that would bring the idle count to 2^WIDTH.
   assign wd_expire = (mode_q == MODE_TICK) && !bus.tick && (idle_q == WD_LAST);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A dropped owner request wins over the terminal compare, so an abort
   // never produces a done pulse; the compare precedes any increment.
   always_comb begin
      state_d    = state_q;
      do_grant   = 1'b0;
      do_inc     = 1'b0;
      do_release = 1'b0;
`ifdef DMC_SCHED_TIMEOUT_EN
      do_err     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req != '0) begin
               state_d  = RUN;
               do_grant = 1'b1;
            end
         end
         RUN: begin
            if (!owner_req) begin
               state_d    = IDLE;
               do_release = 1'b1;
            end else if (at_tgt) begin
               state_d = DONE;
`ifdef DMC_SCHED_TIMEOUT_EN
            end else if (wd_expire) begin
               state_d    = IDLE;
               do_release = 1'b1;
               do_err     = 1'b1;
`endif
            end else if (step) begin
               do_inc = 1'b1;
            end
         end
         DONE: begin
            state_d    = IDLE;
            do_release = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Target and mode are captured only at grant, so client inputs may change
   // freely while the run is in progress. count holds after release.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= 1'b0;
         ptr_q   <= 1'b0;
         mode_q  <= MODE_FREE;
         tgt_q   <= '0;
         count_q <= '0;
         gnt_q   <= '0;
      end else begin
         if (do_grant) begin
            owner_q <= arb_win;
            gnt_q   <= arb_gnt;
            tgt_q   <= arb_win ? bus.tgt1 : bus.tgt0;
            mode_q  <= arb_win ? bus.mode1 : bus.mode0;
            count_q <= '0;
         end else if (do_inc) begin
            count_q <= count_q + 1'b1;
         end
         if (do_release) begin
            gnt_q <= '0;
            ptr_q <= ~owner_q;
         end
      end
   end

`ifdef DMC_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_q <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= do_err;
         if (do_grant) begin
            idle_q <= '0;
         end else if ((state_q == RUN) && (mode_q == MODE_TICK)) begin
            idle_q <= bus.tick ? '0 : idle_q + 1'b1;
         end
      end
   end

   assign bus.err = err_q;
`endif

   assign bus.gnt      = gnt_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE) ? gnt_q : '0;
   assign bus.count    = count_q;
   assign bus.act_mode = mode_q;

endmodule
